// File: rtl/fifo_wr_arb_if.sv
// Write-side bus between N requesters, the arbiter and one FIFO write port.
// The requester/FIFO side uses the master modport. The arbiter uses the slave modport.
interface fifo_wr_arb_if #(
  parameter int DSIZE = 16,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       i_valid;
  logic [NREQ*DSIZE-1:0] i_data;
  logic [NREQ-1:0]       o_ready;
  logic                  o_wr;
  logic [DSIZE-1:0]      o_wdata;
  logic                  i_wfull;

  // Requesters plus FIFO: offer words and report full, observe accepts and writes.
  modport master (
    output i_valid, i_data, i_wfull,
    input  o_ready, o_wr, o_wdata
  );

  // Arbiter: sees requests and full, drives accepts and the FIFO write port.
  modport slave (
    input  i_valid, i_data, i_wfull,
    output o_ready, o_wr, o_wdata
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter that shares one FIFO write port among NREQ requesters.
// Ownership is held for up to BURST words. It ends early when the owner drops valid.
// It stalls, without timing out, while the FIFO reports full.
module fifo_wr_arb #(
  parameter int DSIZE = 16,
  parameter int NREQ  = 4,
  parameter int BURST = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  fifo_wr_arb_if.slave     bus,
  output logic [NREQ-1:0]  o_grant,
  output logic             o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (BURST > 0) ? $clog2(BURST + 1) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;       // last owner; equals the current owner while in GRANT
  logic [CW-1:0]   count;       // words transferred in the current burst
  logic [IW-1:0]   pick;
  logic            pick_found;
  logic            owner_valid;
  logic            xfer;
  logic            last_word;
  logic [NREQ-1:0] ready_c;
  logic            wr_c;
  logic [DSIZE-1:0] wdata_c;

  // Rotating priority search: first asserted valid above the last owner, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    pick       = owner;
    pick_found = 1'b0;
    // Walk from the farthest candidate to the nearest. The nearest valid requester is assigned last.
    for (int i = NREQ; i >= 1; i--) begin
      if (bus.i_valid[(int'(owner) + i) % NREQ]) begin
        pick       = IW'((int'(owner) + i) % NREQ);
        pick_found = 1'b1;
      end
    end
  end

  // Transfer qualification for the current owner.
  always_comb begin
    owner_valid = bus.i_valid[owner];
    xfer        = (state == GRANT) && owner_valid && !bus.i_wfull;
    last_word   = xfer && (count == CW'(BURST - 1));
  end

  // Two-state ownership FSM. Grant, busy and the burst count are registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state   <= IDLE;
      owner   <= IW'(NREQ - 1);
      count   <= '0;
      o_grant <= '0;
      o_busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_en && pick_found) begin
            state   <= GRANT;
            owner   <= pick;
            count   <= '0;
            o_grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            o_busy  <= 1'b1;
          end
        end
        GRANT: begin
          // When the burst completes, count reaches exactly BURST and the FSM exits. The count never wraps.
          if (xfer) count <= count + 1'b1;
          if (!owner_valid || last_word) begin
            state   <= IDLE;
            o_grant <= '0;
            o_busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational write path. It is gated by state, so an async reset silences it at once.
  always_comb begin
    ready_c = '0;
    wr_c    = 1'b0;
    wdata_c = '0;
    if (state == GRANT) begin
      ready_c[owner] = !bus.i_wfull;
      wr_c           = owner_valid && !bus.i_wfull;
      wdata_c        = bus.i_data[int'(owner)*DSIZE +: DSIZE];
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_wr    = wr_c;
  assign bus.o_wdata = wdata_c;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with DSIZE=16, NREQ=4 and BURST=8.
// Requester k presents the word {k[3:0], seq[k]}. seq[k] advances after each transfer the bench expects.
module tb_fifo_wr_arb;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_en;
  logic [3:0] o_grant;
  logic o_busy;

  int checks = 0;
  int errors = 0;
  logic [11:0] seq [4];

  fifo_wr_arb_if #(.DSIZE(16), .NREQ(4)) bus ();

  fifo_wr_arb #(.DSIZE(16), .NREQ(4), .BURST(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .bus     (bus),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_data();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] kid;
      kid = k[3:0];
      bus.i_data[k*16 +: 16] = {kid, seq[k]};
    end
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_en        = 1'b0;
    bus.i_valid = '0;
    bus.i_data  = '0;
    bus.i_wfull = 1'b0;
    for (int k = 0; k < 4; k++) seq[k] = '0;

    // Reset state
    #12;
    check("rst_grant", 64'(o_grant), 64'h0);
    check("rst_busy",  64'(o_busy), 64'h0);
    check("rst_ready", 64'(bus.o_ready), 64'h0);
    check("rst_wr",    64'(bus.o_wr), 64'h0);
    check("rst_wdata", 64'(bus.o_wdata), 64'h0);

    // Requester 0 alone sends 0x1234..0x1236
    i_rst_n = 1'b1;
    i_en = 1'b1;
    bus.i_valid = 4'b0001;
    bus.i_data[15:0] = 16'h1234;
    #1;
    check("idle_ready", 64'(bus.o_ready), 64'h0);
    check("idle_wr",    64'(bus.o_wr), 64'h0);
    step();
    check("r0_grant", 64'(o_grant), 64'h1);
    check("r0_busy",  64'(o_busy), 64'h1);
    check("r0_ready", 64'(bus.o_ready), 64'h1);
    check("r0_wr1",   64'(bus.o_wr), 64'h1);
    check("r0_wd1",   64'(bus.o_wdata), 64'h1234);
    step();
    bus.i_data[15:0] = 16'h1235;
    #1;
    check("r0_wr2", 64'(bus.o_wr), 64'h1);
    check("r0_wd2", 64'(bus.o_wdata), 64'h1235);
    step();
    bus.i_data[15:0] = 16'h1236;
    #1;
    check("r0_wr3", 64'(bus.o_wr), 64'h1);
    check("r0_wd3", 64'(bus.o_wdata), 64'h1236);
    step();
    bus.i_valid = 4'b0000;
    #1;
    check("r0_drop_wr",   64'(bus.o_wr), 64'h0);
    check("r0_drop_busy", 64'(o_busy), 64'h1);
    step();
    check("r0_end_busy",  64'(o_busy), 64'h0);
    check("r0_end_grant", 64'(o_grant), 64'h0);

    // Reset again so the priority pointer restarts at requester 0
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;

    // All four requesters valid: grants 0,1,2,3,0, with 8 words each and one idle cycle between grants
    bus.i_valid = 4'b1111;
    drive_data();
    for (int g = 0; g < 5; g++) begin
      int o;
      o = g % 4;
      step();
      check("rr_grant", 64'(o_grant), 64'(4'b0001 << o));
      for (int w = 0; w < 8; w++) begin
        drive_data();
        #1;
        check("rr_wr",    64'(bus.o_wr), 64'h1);
        check("rr_wdata", 64'(bus.o_wdata), 64'({o[3:0], seq[o]}));
        step();
        seq[o] = seq[o] + 12'd1;
      end
      drive_data();
      #1;
      check("rr_gap_busy", 64'(o_busy), 64'h0);
      check("rr_gap_wr",   64'(bus.o_wr), 64'h0);
    end

    // Requester 2 owns the port. The FIFO is full for 5 cycles after its third word.
    bus.i_valid = 4'b0100;
    #1;
    step();
    check("full_grant", 64'(o_grant), 64'h4);
    for (int w = 0; w < 3; w++) begin
      drive_data();
      #1;
      check("full_pre_wdata", 64'(bus.o_wdata), 64'({4'd2, seq[2]}));
      step();
      seq[2] = seq[2] + 12'd1;
    end
    drive_data();
    bus.i_wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("full_wr",    64'(bus.o_wr), 64'h0);
      check("full_ready", 64'(bus.o_ready), 64'h0);
      check("full_grant_held", 64'(o_grant), 64'h4);
      step();
    end
    bus.i_wfull = 1'b0;
    for (int w = 3; w < 8; w++) begin
      drive_data();
      #1;
      check("full_post_wr",    64'(bus.o_wr), 64'h1);
      check("full_post_wdata", 64'(bus.o_wdata), 64'({4'd2, seq[2]}));
      step();
      seq[2] = seq[2] + 12'd1;
    end
    #1;
    check("full_end_busy", 64'(o_busy), 64'h0);

    // Enable drops during requester 1's burst
    bus.i_valid = 4'b0010;
    drive_data();
    step();
    check("en_grant1", 64'(o_grant), 64'h2);
    for (int w = 0; w < 8; w++) begin
      if (w == 2) begin
        i_en = 1'b0;
        bus.i_valid = 4'b0110;
      end
      drive_data();
      #1;
      check("en_wdata", 64'(bus.o_wdata), 64'({4'd1, seq[1]}));
      if (w == 2) check("en_ready_owner_only", 64'(bus.o_ready), 64'h2);
      step();
      seq[1] = seq[1] + 12'd1;
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      check("en_off_grant", 64'(o_grant), 64'h0);
      check("en_off_busy",  64'(o_busy), 64'h0);
      step();
    end
    i_en = 1'b1;
    #1;
    step();
    check("en_grant2", 64'(o_grant), 64'h4);
    bus.i_valid = 4'b0000;
    #1;
    check("en_drop_wr", 64'(bus.o_wr), 64'h0);
    step();
    check("en_drop_busy", 64'(o_busy), 64'h0);

    // Reset is pulsed in the middle of requester 3's burst
    bus.i_valid = 4'b1000;
    drive_data();
    step();
    check("rstm_grant", 64'(o_grant), 64'h8);
    for (int w = 0; w < 2; w++) begin
      drive_data();
      #1;
      check("rstm_wdata", 64'(bus.o_wdata), 64'({4'd3, seq[3]}));
      step();
      seq[3] = seq[3] + 12'd1;
    end
    drive_data();
    #1;
    check("rstm_wr_before", 64'(bus.o_wr), 64'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rstm_grant0", 64'(o_grant), 64'h0);
    check("rstm_busy0",  64'(o_busy), 64'h0);
    check("rstm_wr0",    64'(bus.o_wr), 64'h0);
    check("rstm_ready0", 64'(bus.o_ready), 64'h0);
    check("rstm_wdata0", 64'(bus.o_wdata), 64'h0);
    step();
    check("rstm_wr_held", 64'(bus.o_wr), 64'h0);
    i_rst_n = 1'b1;
    bus.i_valid = 4'b1111;
    #1;
    check("rstm_idle_busy", 64'(o_busy), 64'h0);
    step();
    check("rstm_first_grant", 64'(o_grant), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DSIZE, default 16, data word width, matching the FIFO write port.
REQ-002 Parameter NREQ, default 4, number of requesters, 2..8.
REQ-003 Parameter BURST, default 8, maximum words per grant, 1..255.
REQ-004 i_clk  input  1  single clock, same domain as the FIFO write side; all logic rising-edge.
REQ-005 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_en  input  1  arbitration enable; low blocks new grants.
REQ-007 i_valid  input  NREQ  per-requester word-valid.
REQ-008 i_data  input  NREQ*DSIZE  requester words, packed flat; requester k occupies bits [k*DSIZE +: DSIZE].
REQ-009 o_ready  output  NREQ  per-requester accept strobe.
REQ-010 o_wr  output  1  FIFO write strobe, to FIFO i_wr.
REQ-011 o_wdata  output  DSIZE  FIFO write data, to FIFO i_wdata.
REQ-012 i_wfull  input  1  FIFO full flag, from FIFO o_wfull.
REQ-013 o_grant  output  NREQ  one-hot current owner; all-zero when no grant is held.
REQ-014 o_busy  output  1  high while in GRANT.

Function
REQ-015 The FSM SHALL have two states.
- IDLE: no owner.
- GRANT: one owner holds the FIFO write port.
REQ-016 IDLE -> GRANT SHALL occur on a clock edge when i_en=1 and |i_valid=1.
- Owner = first asserted i_valid found searching upward, modulo NREQ, from (last_owner+1).
- last_owner resets to NREQ-1, so requester 0 has first priority after reset.
REQ-017 On entering GRANT, the block SHALL:
- latch the owner into o_grant and last_owner;
- clear the burst counter.
REQ-018 A transfer occurs in a GRANT cycle when i_valid[owner]=1 and i_wfull=0.
REQ-019 In GRANT, the combinational outputs SHALL be:
- o_ready[owner] = ~i_wfull; all other o_ready bits = 0;
- o_wr = i_valid[owner] & ~i_wfull;
- o_wdata = owner's word.
REQ-020 In IDLE, o_ready SHALL be all-zero, o_wr=0 and o_wdata=0.
REQ-021 The burst counter SHALL:
- increment by 1 on each transfer only;
- use width ceil(log2(BURST+1));
- never wrap.
REQ-022 GRANT -> IDLE SHALL occur on the edge ending a cycle in which either:
- a transfer brings the count to BURST, or
- i_valid[owner]=0.
REQ-023 While i_wfull=1 with i_valid[owner]=1, the block SHALL hold the grant indefinitely: no transfer, no count change, no release.
REQ-024 Arbitration latency SHALL be exactly one cycle from i_valid assertion in IDLE to o_ready in GRANT.
- Every release SHALL be followed by at least one IDLE cycle.
REQ-025 When i_en falls during GRANT, the current burst SHALL complete normally; no new grant is issued until i_en=1.
REQ-026 A requester dropping i_valid while not owner SHALL be ignored; no request state is stored per requester.
REQ-027 Words SHALL be written to the FIFO in exactly the order each requester presented them, with no drop or duplication.

Reset
REQ-028 While i_rst_n=0, the block SHALL asynchronously hold:
- state=IDLE, burst count=0, last_owner=NREQ-1;
- o_grant=0, o_busy=0, o_ready=0, o_wr=0, o_wdata=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately with no further o_wr.
- The first grant after release SHALL follow REQ-016 from the reset priority.
REQ-030 State SHALL leave reset on the first rising i_clk after i_rst_n rises; no synchronizer is included in this block.

Verification
REQ-031 Reset release, i_valid=4'b0001 for 3 words 0x1234..0x1236 -> o_grant=0001 one cycle later; 3 o_wr pulses in order; then o_busy=0.
REQ-032 i_valid=4'b1111 held continuously, BURST=8, i_wfull=0 -> grants 0,1,2,3,0 in turn; exactly 8 writes each; one IDLE cycle between grants.
REQ-033 Requester 2 owner, i_wfull=1 for 5 cycles after word 3 -> o_wr=0 and o_ready=0 for those 5 cycles; grant held; count stays 3; writes resume in order after i_wfull falls.
REQ-034 i_en=0 during owner-1 burst -> burst finishes at 8 words or on valid drop; no further grant while i_en=0; grant to 2 on the first edge with i_en=1.
REQ-035 i_rst_n=0 pulsed mid-burst of owner 3 -> outputs zero immediately; after release with all valid, requester 0 is granted first.
REQ-036 Connected to the async FIFO (DSIZE=16, ASIZE=8) with 4 counting sources and 2:1 write:read clock ratio -> read stream per source is strictly incrementing; total words read = total words written.
